vga_pixel_feeder: RTL and testbench

VGA_PIXEL_FEEDER -- requirements
Module: vga_pixel_feeder

---
 rtl/vga_pixel_feeder_if.sv | 23 ++
 rtl/vga_pixel_feeder.sv | 97 +++++++++
 tb/tb_vga_pixel_feeder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/vga_pixel_feeder_if.sv
// rtl/vga_pixel_feeder_if.sv - producer stream and VGA pixel-request bundle for vga_pixel_feeder
// The master drives pixels and requests. The slave (the feeder) returns ready and the pixel colour.
interface vga_pixel_feeder_if #(
  parameter int RGB_SIZE = 8
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic [3*RGB_SIZE-1:0]   in_pixel;
  logic                    pix_req;
  logic [RGB_SIZE-1:0]     vga_red;
  logic [RGB_SIZE-1:0]     vga_green;
  logic [RGB_SIZE-1:0]     vga_blue;

  modport master (
    output in_valid, in_pixel, pix_req,
    input  in_ready, vga_red, vga_green, vga_blue
  );

  modport slave (
    input  in_valid, in_pixel, pix_req,
    output in_ready, vga_red, vga_green, vga_blue
  );
endinterface

// File: rtl/vga_pixel_feeder.sv
// rtl/vga_pixel_feeder.sv - prefilling pixel FIFO that feeds a VGA controller, one pixel per request
// Optional saturating underflow_count port: define VGA_PIXEL_FEEDER_UNDERFLOW_CNT_EN.
module vga_pixel_feeder #(
  parameter int RGB_SIZE = 8,
  parameter int DEPTH    = 16,
  parameter int PREFILL  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  vga_pixel_feeder_if.slave      bus,
  input  logic                   frame_start,
  output logic [$clog2(DEPTH):0] level,
  output logic                   streaming,
  output logic                   underflow
`ifdef VGA_PIXEL_FEEDER_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]            underflow_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = 3 * RGB_SIZE;

  typedef enum logic {FILL, STREAM} state_t;

  state_t          state;
  logic [PW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     level_q;
  logic [AW:0]     level_next;
  logic [PW-1:0]   vga_q;
  logic            push;
  logic            pop;

  assign bus.in_ready  = (level_q < (AW+1)'(DEPTH));
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = (state == STREAM) && bus.pix_req && (level_q != '0);
  assign level_next    = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  assign level         = level_q;
  assign streaming     = (state == STREAM);
  assign bus.vga_red   = vga_q[PW-1 -: RGB_SIZE];
  assign bus.vga_green = vga_q[2*RGB_SIZE-1 -: RGB_SIZE];
  assign bus.vga_blue  = vga_q[RGB_SIZE-1:0];

  // Storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !frame_start) begin
      mem[wr_ptr] <= bus.in_pixel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FILL;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      vga_q     <= '0;
      underflow <= 1'b0;
`ifdef VGA_PIXEL_FEEDER_UNDERFLOW_CNT_EN
      underflow_count <= '0;
`endif
    end else if (frame_start) begin
      state   <= FILL;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      vga_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        vga_q  <= mem[rd_ptr];
      end else if (bus.pix_req) begin
        // No bypass: a request at empty blanks the pixel even if a push lands this cycle.
        vga_q <= '0;
        if (state == STREAM) begin
          underflow <= 1'b1;
`ifdef VGA_PIXEL_FEEDER_UNDERFLOW_CNT_EN
          if (underflow_count != 16'hFFFF) begin
            underflow_count <= underflow_count + 16'd1;
          end
`endif
        end
      end
      level_q <= level_next;
      if (state == FILL && level_next >= (AW+1)'(PREFILL)) begin
        state <= STREAM;
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// tb/tb_vga_pixel_feeder.sv - self-checking bench for vga_pixel_feeder against a queue-based reference
module tb_vga_pixel_feeder;

  localparam int DEPTH   = 16;
  localparam int PREFILL = 8;

  logic       clk;
  logic       reset;
  logic       frame_start;
  logic [4:0] level;
  logic       streaming;
  logic       underflow;
`ifdef VGA_PIXEL_FEEDER_UNDERFLOW_CNT_EN
  logic [15:0] underflow_count;
`endif

  vga_pixel_feeder_if #(.RGB_SIZE(8)) bus ();

  vga_pixel_feeder #(.RGB_SIZE(8), .DEPTH(DEPTH), .PREFILL(PREFILL)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .frame_start (frame_start),
    .level       (level),
    .streaming   (streaming),
    .underflow   (underflow)
`ifdef VGA_PIXEL_FEEDER_UNDERFLOW_CNT_EN
    ,
    .underflow_count (underflow_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the FIFO is a queue, the mode is a flag.
  logic [23:0] m_q[$];
  bit          m_stream;
  logic [23:0] m_vga;
  bit          m_under;
  int          m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      $error("%s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_stream = 0;
    m_vga    = '0;
    m_under  = 0;
    m_cnt    = 0;
  endtask

  task automatic model_edge(input logic v, input logic [23:0] px, input logic rq, input logic fs);
    bit can_push;
    can_push = v && (m_q.size() < DEPTH);
    if (fs) begin
      m_q.delete();
      m_stream = 0;
      m_vga    = '0;
    end else begin
      if (rq) begin
        if (m_stream && m_q.size() > 0) begin
          m_vga = m_q.pop_front();
        end else begin
          m_vga = '0;
          if (m_stream) begin
            m_under = 1;
            if (m_cnt < 65535) m_cnt++;
          end
        end
      end
      if (can_push) m_q.push_back(px);
      if (!m_stream && m_q.size() >= PREFILL) m_stream = 1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".level"},     32'(level), 32'(m_q.size()));
    check({tag, ".in_ready"},  32'(bus.in_ready), 32'(m_q.size() < DEPTH));
    check({tag, ".vga"},       32'({bus.vga_red, bus.vga_green, bus.vga_blue}), 32'(m_vga));
    check({tag, ".streaming"}, 32'(streaming), 32'(m_stream));
    check({tag, ".underflow"}, 32'(underflow), 32'(m_under));
`ifdef VGA_PIXEL_FEEDER_UNDERFLOW_CNT_EN
    check({tag, ".ucount"},    32'(underflow_count), 32'(m_cnt));
`endif
  endtask

  task automatic step(input string tag, input logic v, input logic [23:0] px,
                      input logic rq, input logic fs);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_pixel = px;
    bus.pix_req  = rq;
    frame_start  = fs;
    @(posedge clk);
    model_edge(v, px, rq, fs);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_pixel = '0;
    bus.pix_req  = 1'b0;
    frame_start  = 1'b0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    reset = 1'b1;
    #3;
    check_all("reset");

    @(negedge clk);
    reset = 1'b0;

    // Prefill: streaming rises on the 8th push.
    for (int i = 0; i < PREFILL; i++) step("prefill", 1'b1, 24'($urandom), 1'b0, 1'b0);
    check("prefill.stream_on", 32'(streaming), 32'd1);
    check("prefill.level8", 32'(level), 32'd8);

    // Ordering: red then green, each one cycle after its request.
    step("flush0", 1'b0, '0, 1'b0, 1'b1);
    step("ord", 1'b1, 24'hFF0000, 1'b0, 1'b0);
    step("ord", 1'b1, 24'h00FF00, 1'b0, 1'b0);
    for (int i = 0; i < PREFILL - 2; i++) step("ord", 1'b1, 24'($urandom), 1'b0, 1'b0);
    step("ord_req1", 1'b0, '0, 1'b1, 1'b0);
    check("ord.red", 32'({bus.vga_red, bus.vga_green, bus.vga_blue}), 32'h00FF0000);
    step("ord_req2", 1'b0, '0, 1'b1, 1'b0);
    check("ord.green", 32'({bus.vga_red, bus.vga_green, bus.vga_blue}), 32'h0000FF00);
    step("ord_hold", 1'b0, '0, 1'b0, 1'b0);

    // Full: 17 pushes with no requests, then drain past empty.
    step("flush1", 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step("full", 1'b1, 24'($urandom), 1'b0, 1'b0);
    check("full.in_ready_low", 32'(bus.in_ready), 32'd0);
    step("full17", 1'b1, 24'h123456, 1'b0, 1'b0);
    check("full.level16", 32'(level), 32'd16);
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
    step("under", 1'b0, '0, 1'b1, 1'b0);
    check("under.flag", 32'(underflow), 32'd1);
    check("under.vga0", 32'({bus.vga_red, bus.vga_green, bus.vga_blue}), 32'd0);
`ifdef VGA_PIXEL_FEEDER_UNDERFLOW_CNT_EN
    check("under.count1", 32'(underflow_count), 32'd1);
`endif

    // Flush at level 5 with simultaneous push and request.
    step("flush2", 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < PREFILL; i++) step("fl", 1'b1, 24'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("fl", 1'b0, '0, 1'b1, 1'b0);
    check("fl.level5", 32'(level), 32'd5);
    step("fl_hit", 1'b1, 24'hABCDEF, 1'b1, 1'b1);
    check("fl.level0", 32'(level), 32'd0);
    check("fl.fill", 32'(streaming), 32'd0);
    check("fl.sticky_under", 32'(underflow), 32'd1);
    step("fl_after", 1'b0, '0, 1'b0, 1'b0);

    // Random traffic with occasional frame_start.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), 24'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0));
    end

    // Mid-stream asynchronous reset at level 10.
    step("flush3", 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step("pre_rst", 1'b1, 24'($urandom), 1'b0, 1'b0);
    check("pre_rst.level10", 32'(level), 32'd10);
    @(negedge clk);
    idle_inputs();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b0;
    step("post_rst", 1'b1, 24'h0000FF, 1'b0, 1'b0);
    step("post_rst", 1'b1, 24'h00FF00, 1'b1, 1'b0);
    check("post_rst.level2", 32'(level), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
